control_request_initiator: RTL and testbench
============================================

// Module: control_request_initiator
// PURPOSE
//  Host-side counterpart of the control endpoint. Packs the 8-byte SETUP fields into the
//  64-bit setup word and presents it with an enable pulse. Tracks the endpoint's busy handshake.
//  For IN requests, it also collects 16-bit data-stage words until wLength bytes have arrived.
//  Sits between the transaction scheduler and the control endpoint's data/enable/busy/data_out16 ports.
// PARAMETERS
//  MAX_LEN        64   largest wLength accepted; larger requests are clamped to MAX_LEN
//  TIMEOUT_CYCLES 255  watchdog limit in clk cycles (used only with CTRL_INIT_TIMEOUT_EN)
// PORTS
//  clk            in   1   system clock, all logic on rising edge
//  rst            in   1   synchronous reset, active-low
//  start          in   1   request strobe; sampled only in IDLE
//  bmRequestType  in   8   request type; bit7=1 IN (device-to-host), 0 OUT
//  bRequest       in   8   request code
//  wValue         in   16  request value
//  wIndex         in   16  request index
//  wLength        in   16  data-stage length in bytes
//  busy           in   1   endpoint busy (from control endpoint)
//  data_in16      in   16  data-stage word from endpoint; low byte first
//  data_in_valid  in   1   data_in16 qualifier
//  data           out  64  setup word to endpoint
//  enable         out  1   setup-valid strobe to endpoint
//  resp_data      out  16  captured data-stage word
//  resp_valid     out  1   resp_data qualifier, one cycle per word
//  resp_bytes     out  2   valid bytes in resp_data (1 or 2)
//  ready          out  1   high in IDLE only
//  done           out  1   one-cycle completion pulse
//  error          out  1   one-cycle abort pulse (timeout)
// BEHAVIOUR
//  Reset (rst==0 at clk edge): state=IDLE; data=0, enable=0, resp_data=0, resp_valid=0,
//   resp_bytes=0, done=0, error=0, ready=1. Reset aborts any transfer in progress immediately.
//  Packing: data={bmRequestType,bRequest,wValue,wIndex,wLength_eff}, bit-exact:
//   [63:56],[55:48],[47:32],[31:16],[15:0]. wLength_eff=min(wLength,MAX_LEN).
//  FSM states: IDLE, SETUP, WAIT_ACK, DATA, STATUS.
//  IDLE: start=1 and busy=0 -> latch all fields, go to SETUP.
//   start while busy=1 is ignored (not queued).
//  SETUP: data holds the packed word; enable=1 for exactly this one cycle -> WAIT_ACK.
//   data holds its value until the next SETUP.
//  WAIT_ACK: wait for busy=1, then branch:
//   - bmRequestType[7]=1 and wLength_eff!=0 -> DATA, remaining=wLength_eff;
//   - otherwise (OUT request or zero length) -> STATUS.
//  DATA: on each data_in_valid, resp_data<=data_in16 and resp_valid=1 on the next cycle.
//   resp_bytes=2 if remaining>=2, else 1.
//   remaining -= resp_bytes, never underflows.
//   remaining reaches 0 -> STATUS; extra valid words after that are dropped.
//  STATUS: wait for busy=0 -> done=1 for one cycle, return to IDLE (ready=1 in the same cycle as done).
//  Latency: start -> enable is 1 cycle; last data word -> resp_valid is 1 cycle.
//  busy falling during DATA (endpoint ended early): go to STATUS, then done. No error is raised.
//  Simultaneous data_in_valid and busy falling in DATA: the word is still captured.
// CONFIGURATION
//  CTRL_INIT_TIMEOUT_EN defined:
//   - a watchdog counts cycles spent in WAIT_ACK, DATA and STATUS; it clears on every state
//     change and on every data_in_valid;
//   - reaching TIMEOUT_CYCLES -> error=1 for one cycle, state=IDLE, done stays 0.
//  Not defined: no watchdog, error is tied to 0, and the FSM waits indefinitely.
// TESTING
//  1 GET_DESCRIPTOR: start with 80/06/0100/0000/0012.
//    -> data=64'h8006_0100_0000_0012 and enable is a one-cycle pulse.
//    -> nine resp_valid beats, each with resp_bytes=2, then done.
//  2 Odd length: IN request with wLength=3, endpoint supplies 2 words.
//    -> resp_bytes sequence 2,1, then done; a third supplied word is dropped.
//  3 OUT request 00/09/0001/0000/0000.
//    -> data=64'h0009_0001_0000_0000, no resp_valid beats, done after busy falls.
//  4 Clamp: wLength=16'h00FF with MAX_LEN=64.
//    -> data[15:0]=16'h0040 and exactly 32 response beats.
//  5 Reset mid-transfer: drive rst=0 in DATA after 2 words.
//    -> next cycle state=IDLE, ready=1, all outputs 0, no done pulse.
//  6 Watchdog (CTRL_INIT_TIMEOUT_EN, TIMEOUT_CYCLES=255): busy never asserts.
//    -> error pulses 255 cycles after enable, ready=1; without the macro, still in WAIT_ACK.

Source files
------------

// File: rtl/control_request_initiator.sv
// Host-side control request initiator: packs SETUP fields, tracks busy, collects IN data.
// Optional watchdog abort enabled with `define CTRL_INIT_TIMEOUT_EN.
module control_request_initiator #(
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bmRequestType,
  input  logic [7:0]  bRequest,
  input  logic [15:0] wValue,
  input  logic [15:0] wIndex,
  input  logic [15:0] wLength,
  input  logic        busy,
  input  logic [15:0] data_in16,
  input  logic        data_in_valid,
  output logic [63:0] data,
  output logic        enable,
  output logic [15:0] resp_data,
  output logic        resp_valid,
  output logic [1:0]  resp_bytes,
  output logic        ready,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, SETUP, WAIT_ACK, DATA, STATUS
  } state_t;

  state_t      state_q, state_d, nxt_state;
  logic [63:0] data_q, data_d;
  logic        enable_q, enable_d;
  logic [15:0] resp_data_q, resp_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic [1:0]  resp_bytes_q, resp_bytes_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] wlen_eff;
  logic [1:0]  beat_bytes;
  logic        wd_fire;

  assign wlen_eff = (wLength > 16'(MAX_LEN)) ? 16'(MAX_LEN) : wLength;
  assign beat_bytes = (rem_q >= 16'd2) ? 2'd2 : 2'd1;

  always_comb begin
    nxt_state    = state_q;
    data_d       = data_q;
    enable_d     = 1'b0;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    resp_bytes_d = 2'd0;
    done_d       = 1'b0;
    rem_d        = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start && !busy) begin
          nxt_state = SETUP;
          data_d    = {bmRequestType, bRequest, wValue,
                       wIndex, wlen_eff};
          enable_d  = 1'b1;
        end
      end
      SETUP: nxt_state = WAIT_ACK;
      WAIT_ACK: begin
        if (busy) begin
          if (data_q[63] && data_q[15:0] != 16'd0) begin
            nxt_state = DATA;
            rem_d     = data_q[15:0];
          end else begin
            nxt_state = STATUS;
          end
        end
      end
      DATA: begin
        if (data_in_valid) begin
          resp_data_d  = data_in16;
          resp_valid_d = 1'b1;
          resp_bytes_d = beat_bytes;
          rem_d        = rem_q - {14'd0, beat_bytes};
        end
        if (rem_d == 16'd0 || !busy)
          nxt_state = STATUS;
      end
      STATUS: begin
        if (!busy) begin
          nxt_state = IDLE;
          done_d    = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
    state_d = wd_fire ? IDLE : nxt_state;
    if (wd_fire)
      done_d = 1'b0;
    ready_d = (state_d == IDLE);
  end

`ifdef CTRL_INIT_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        error_q;
  logic        wd_active;
  logic        wd_clr;

  assign wd_active = (state_q == WAIT_ACK) ||
                     (state_q == DATA) ||
                     (state_q == STATUS);
  assign wd_clr = !wd_active || nxt_state != state_q ||
                  data_in_valid;
  // The SETUP cycle is part of the budget, hence the limit minus two.
  assign wd_fire = !wd_clr &&
                   wd_q == 16'(TIMEOUT_CYCLES - 2);
  assign wd_d = (wd_clr || wd_fire) ? 16'd0 : wd_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q    <= 16'd0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= wd_fire;
    end
  end

  assign error = error_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^16'(TIMEOUT_CYCLES);
  assign wd_fire = 1'b0;
  assign error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      data_q       <= 64'd0;
      enable_q     <= 1'b0;
      resp_data_q  <= 16'd0;
      resp_valid_q <= 1'b0;
      resp_bytes_q <= 2'd0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      rem_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      enable_q     <= enable_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      resp_bytes_q <= resp_bytes_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      rem_q        <= rem_d;
    end
  end

  assign data       = data_q;
  assign enable     = enable_q;
  assign resp_data  = resp_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_bytes = resp_bytes_q;
  assign ready      = ready_q;
  assign done       = done_q;

endmodule

// File: tb/tb_control_request_initiator.sv
// Directed bench for control_request_initiator.
// Watchdog expectations follow CTRL_INIT_TIMEOUT_EN when defined.
module tb_control_request_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bmRequestType;
  logic [7:0]  bRequest;
  logic [15:0] wValue;
  logic [15:0] wIndex;
  logic [15:0] wLength;
  logic        busy;
  logic [15:0] data_in16;
  logic        data_in_valid;
  logic [63:0] data;
  logic        enable;
  logic [15:0] resp_data;
  logic        resp_valid;
  logic [1:0]  resp_bytes;
  logic        ready;
  logic        done;
  logic        error;

  int n_cmp = 0;
  int n_err = 0;
  int beats;

  control_request_initiator #(
    .MAX_LEN(64),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .bmRequestType(bmRequestType), .bRequest(bRequest),
    .wValue(wValue), .wIndex(wIndex), .wLength(wLength),
    .busy(busy), .data_in16(data_in16),
    .data_in_valid(data_in_valid),
    .data(data), .enable(enable),
    .resp_data(resp_data), .resp_valid(resp_valid),
    .resp_bytes(resp_bytes), .ready(ready),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] t, input logic [7:0] r,
                       input logic [15:0] v, input logic [15:0] i,
                       input logic [15:0] l);
    bmRequestType = t; bRequest = r;
    wValue = v; wIndex = i; wLength = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; busy = 1'b0;
    bmRequestType = 8'h0; bRequest = 8'h0;
    wValue = 16'h0; wIndex = 16'h0; wLength = 16'h0;
    data_in16 = 16'h0; data_in_valid = 1'b0;
    tick(); tick();
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_data", data, 64'd0);
    check("rst_enable", 64'(enable), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_rbytes", 64'(resp_bytes), 64'd0);
    rst = 1'b1;
    tick();

    // start ignored while busy
    busy = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_ign_en", 64'(enable), 64'd0);
    check("busy_ign_rdy", 64'(ready), 64'd1);
    busy = 1'b0;
    tick();

    // GET_DESCRIPTOR, 18 bytes -> 9 beats
    issue(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012);
    check("t1_data", data, 64'h8006_0100_0000_0012);
    check("t1_en_hi", 64'(enable), 64'd1);
    check("t1_rdy_lo", 64'(ready), 64'd0);
    tick();
    check("t1_en_lo", 64'(enable), 64'd0);
    busy = 1'b1;
    tick();
    beats = 0;
    for (int k = 0; k < 9; k++) begin
      data_in_valid = 1'b1;
      data_in16 = 16'hA000 + 16'(k);
      tick();
      if (resp_valid) beats++;
      check("t1_rbytes", 64'(resp_bytes), 64'd2);
      check("t1_rdata", 64'(resp_data), 64'hA000 + 64'(k));
    end
    data_in_valid = 1'b0;
    tick();
    check("t1_beats", 64'(beats), 64'd9);
    check("t1_nodone", 64'(done), 64'd0);
    busy = 1'b0;
    tick();
    check("t1_done", 64'(done), 64'd1);
    check("t1_rdy", 64'(ready), 64'd1);
    tick();
    check("t1_done_lo", 64'(done), 64'd0);

    // odd length, extra word dropped
    issue(8'hC0, 8'h01, 16'h0000, 16'h0000, 16'h0003);
    tick();
    busy = 1'b1;
    tick();
    data_in_valid = 1'b1; data_in16 = 16'h1122;
    tick();
    check("t2_v0", 64'(resp_valid), 64'd1);
    check("t2_b0", 64'(resp_bytes), 64'd2);
    data_in16 = 16'h0033;
    tick();
    check("t2_v1", 64'(resp_valid), 64'd1);
    check("t2_b1", 64'(resp_bytes), 64'd1);
    check("t2_d1", 64'(resp_data), 64'h0033);
    data_in16 = 16'h4455;
    tick();
    check("t2_drop", 64'(resp_valid), 64'd0);
    data_in_valid = 1'b0; busy = 1'b0;
    tick();
    check("t2_done", 64'(done), 64'd1);

    // OUT request, no data stage
    beats = 0;
    issue(8'h00, 8'h09, 16'h0001, 16'h0000, 16'h0000);
    check("t3_data", data, 64'h0009_0001_0000_0000);
    tick();
    busy = 1'b1;
    tick();
    if (resp_valid) beats++;
    tick();
    if (resp_valid) beats++;
    check("t3_wait", 64'(done), 64'd0);
    busy = 1'b0;
    tick();
    check("t3_done", 64'(done), 64'd1);
    check("t3_beats", 64'(beats), 64'd0);

    // clamp 0xFF -> 64 bytes -> 32 beats
    issue(8'h80, 8'h06, 16'h0200, 16'h0000, 16'h00FF);
    check("t4_len", 64'(data[15:0]), 64'h0040);
    tick();
    busy = 1'b1;
    tick();
    beats = 0;
    data_in_valid = 1'b1;
    for (int k = 0; k < 34; k++) begin
      data_in16 = 16'(k);
      tick();
      if (resp_valid) beats++;
    end
    data_in_valid = 1'b0;
    check("t4_beats", 64'(beats), 64'd32);
    busy = 1'b0;
    tick();
    check("t4_done", 64'(done), 64'd1);

    // reset during DATA
    issue(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0008);
    tick();
    busy = 1'b1;
    tick();
    data_in_valid = 1'b1; data_in16 = 16'hBEEF;
    tick(); tick();
    data_in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("t5_rdy", 64'(ready), 64'd1);
    check("t5_data", data, 64'd0);
    check("t5_rv", 64'(resp_valid), 64'd0);
    check("t5_rd", 64'(resp_data), 64'd0);
    rst = 1'b1; busy = 1'b0;
    tick();
    check("t5_nodone", 64'(done), 64'd0);
    check("t5_rdy2", 64'(ready), 64'd1);

    // busy falls together with a word in DATA
    issue(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0008);
    tick();
    busy = 1'b1;
    tick();
    data_in_valid = 1'b1; data_in16 = 16'h7788; busy = 1'b0;
    tick();
    data_in_valid = 1'b0;
    check("t7_cap", 64'(resp_valid), 64'd1);
    check("t7_data", 64'(resp_data), 64'h7788);
    tick();
    check("t7_done", 64'(done), 64'd1);
    check("t7_err", 64'(error), 64'd0);

    // watchdog: busy never rises
    issue(8'h00, 8'h05, 16'h0003, 16'h0000, 16'h0000);
    for (int k = 0; k < 254; k++) tick();
    check("t6_err_pre", 64'(error), 64'd0);
    tick();
`ifdef CTRL_INIT_TIMEOUT_EN
    check("t6_err", 64'(error), 64'd1);
    check("t6_rdy", 64'(ready), 64'd1);
    check("t6_done", 64'(done), 64'd0);
    tick();
    check("t6_err_lo", 64'(error), 64'd0);
`else
    check("t6_err", 64'(error), 64'd0);
    check("t6_wait", 64'(ready), 64'd0);
    busy = 1'b1;
    tick();
    busy = 1'b0;
    tick();
    check("t6_done", 64'(done), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
